// File: rtl/polar_time_surface.sv
// Per-polarity time-surface store: last-event timestamp per cell and channel,
// self-clearing on reset, with lazily evaluated decay on a two-stage read pipeline.
module polar_time_surface #(
  parameter int GRID_SIZE   = 32,
  parameter int NUM_CH      = 2,
  parameter int TS_BITS     = 16,
  parameter int VALUE_BITS  = 8,
  parameter int MAX_VALUE   = 255,
  parameter int DECAY_SHIFT = 6,
  parameter int LIN_SHIFT   = 2,
  parameter int WINDOW      = 256,
  parameter int CH_BITS     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int XY_BITS     = $clog2(GRID_SIZE),
  parameter int CELL_BITS   = $clog2(GRID_SIZE * GRID_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TS_BITS-1:0]    t_now,
  input  logic [1:0]            decay_mode,
  input  logic                  ev_valid,
  input  logic [XY_BITS-1:0]    ev_x,
  input  logic [XY_BITS-1:0]    ev_y,
  input  logic [CH_BITS-1:0]    ev_ch,
  input  logic [TS_BITS-1:0]    ev_ts,
  input  logic                  rd_req,
  input  logic [CELL_BITS-1:0]  rd_addr,
  input  logic [CH_BITS-1:0]    rd_ch,
  output logic                  rd_valid,
  output logic [VALUE_BITS-1:0] rd_value,
  output logic                  rd_hit,
  output logic [TS_BITS-1:0]    rd_ts,
  output logic                  init_done,
  output logic [15:0]           drop_count
);

  localparam int CELLS = GRID_SIZE * GRID_SIZE;
  localparam int DEPTH = NUM_CH * CELLS;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [AW-1:0]      LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [TS_BITS-1:0] MAX_TS    = TS_BITS'(MAX_VALUE);
  localparam logic [TS_BITS-1:0] WIN_TS    = TS_BITS'(WINDOW);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  // Linear law saturates at zero once the slope has consumed the full value.
  function automatic logic [TS_BITS-1:0] lin_sat(input logic [TS_BITS-1:0] s);
    return (s > MAX_TS) ? '0 : (MAX_TS - s);
  endfunction

  function automatic logic [VALUE_BITS-1:0] decay_value(input logic [1:0] mode,
                                                        input logic [TS_BITS-1:0] dt);
    logic [TS_BITS-1:0] k;
    logic [TS_BITS-1:0] v;
    k = dt >> DECAY_SHIFT;
    v = '0;
    case (mode)
      2'd1:    v = lin_sat(dt >> LIN_SHIFT);
      2'd2:    v = (dt < WIN_TS) ? MAX_TS : '0;
      default: v = (k >= TS_BITS'(VALUE_BITS)) ? '0 : (MAX_TS >> k);
    endcase
    return VALUE_BITS'(v);
  endfunction

  state_t        state;
  logic [AW-1:0] clr_addr;

  logic [TS_BITS:0] mem [DEPTH];

  logic [AW-1:0]    ev_idx;
  logic [AW-1:0]    rd_idx;
  logic             ev_wr;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [TS_BITS:0] mem_wdata;

  always_comb begin
    ev_idx    = AW'(ev_ch) * AW'(CELLS) + AW'(ev_y) * AW'(GRID_SIZE) + AW'(ev_x);
    rd_idx    = AW'(rd_ch) * AW'(CELLS) + AW'(rd_addr);
    ev_wr     = (state == S_READY) && ev_valid && !rst;
    mem_we    = (state == S_CLEAR) || ev_wr;
    mem_waddr = (state == S_CLEAR) ? clr_addr : ev_idx;
    mem_wdata = (state == S_CLEAR) ? '0 : {1'b1, ev_ts};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_CLEAR;
      clr_addr   <= '0;
      init_done  <= 1'b0;
      drop_count <= '0;
    end else begin
      case (state)
        S_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == LAST_ADDR) begin
            state     <= S_READY;
            init_done <= 1'b1;
          end
          if (ev_valid && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
        default: state <= S_READY;
      endcase
    end
  end

  // Stage 1: RAM read, plus same-cycle write capture for write-first forwarding
  logic             vld_p1;
  logic [TS_BITS:0] ram_q_p1;
  logic             fwd_p1;
  logic [TS_BITS-1:0] fwd_ts_p1;
  logic             clr_p1;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    ram_q_p1 <= mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= rd_req;
    fwd_p1    <= ev_wr && (ev_idx == rd_idx);
    fwd_ts_p1 <= ev_ts;
    clr_p1    <= (state == S_CLEAR);
  end

  logic               hit_p1;
  logic [TS_BITS-1:0] ts_p1;
  logic [TS_BITS-1:0] dt_p1;
  logic [VALUE_BITS-1:0] value_p1;

  always_comb begin
    hit_p1 = ram_q_p1[TS_BITS];
    ts_p1  = ram_q_p1[TS_BITS-1:0];
    if (clr_p1) begin
      hit_p1 = 1'b0;
      ts_p1  = '0;
    end else if (fwd_p1) begin
      hit_p1 = 1'b1;
      ts_p1  = fwd_ts_p1;
    end
    // Modular age; a set MSB means expired or timestamped in the future.
    dt_p1    = t_now - ts_p1;
    value_p1 = (hit_p1 && !dt_p1[TS_BITS-1]) ? decay_value(decay_mode, dt_p1) : '0;
  end

  // Stage 2: registered decay result
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_value <= '0;
      rd_hit   <= 1'b0;
      rd_ts    <= '0;
    end else begin
      rd_valid <= vld_p1;
      if (vld_p1) begin
        rd_value <= value_p1;
        rd_hit   <= hit_p1;
        rd_ts    <= ts_p1;
      end
    end
  end

endmodule

// File: tb/tb_polar_time_surface.sv
// Directed bench for polar_time_surface: init sweep, decay laws, wrap handling,
// forwarding, throughput and mid-stream reset.
module tb_polar_time_surface;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] t_now;
  logic [1:0]  decay_mode;
  logic        ev_valid;
  logic [4:0]  ev_x, ev_y;
  logic [0:0]  ev_ch;
  logic [15:0] ev_ts;
  logic        rd_req;
  logic [9:0]  rd_addr;
  logic [0:0]  rd_ch;
  logic        rd_valid;
  logic [7:0]  rd_value;
  logic        rd_hit;
  logic [15:0] rd_ts;
  logic        init_done;
  logic [15:0] drop_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  polar_time_surface dut (
    .clk(clk), .rst(rst), .t_now(t_now), .decay_mode(decay_mode),
    .ev_valid(ev_valid), .ev_x(ev_x), .ev_y(ev_y), .ev_ch(ev_ch), .ev_ts(ev_ts),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ch(rd_ch),
    .rd_valid(rd_valid), .rd_value(rd_value), .rd_hit(rd_hit), .rd_ts(rd_ts),
    .init_done(init_done), .drop_count(drop_count)
  );

  task automatic write_ev(input logic [4:0] x, input logic [4:0] y, input logic ch,
                          input logic [15:0] ts);
    @(negedge clk);
    ev_valid = 1'b1; ev_x = x; ev_y = y; ev_ch = ch; ev_ts = ts;
    @(negedge clk);
    ev_valid = 1'b0;
  endtask

  // Issues one read and returns rd_valid one and two cycles later plus the result.
  task automatic do_read(input logic [9:0] addr, input logic ch,
                         output logic v1, output logic v2, output logic [7:0] val,
                         output logic hit, output logic [15:0] ts);
    @(negedge clk);
    rd_req = 1'b1; rd_addr = addr; rd_ch = ch;
    @(negedge clk);
    rd_req = 1'b0;
    v1 = rd_valid;
    @(negedge clk);
    v2 = rd_valid; val = rd_value; hit = rd_hit; ts = rd_ts;
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (!init_done && n < 2200) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!init_done) begin
      errors++;
      $display("FAIL %s: init_done not seen within %0d cycles", name, n);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rd_valid, rd_hit, init_done} !== 3'b000 || rd_value !== 8'd0 || rd_ts !== 16'd0 ||
        drop_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b hit=%b init=%b value=%0d ts=%0d drop=%0d, want all 0",
               rd_valid, rd_hit, init_done, rd_value, rd_ts, drop_count);
    end
  endtask

  task automatic test_init;
    int cnt;
    logic seen;
    cnt = 0;
    seen = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    while (!seen && cnt < 3000) begin
      @(posedge clk); #1;
      cnt++;
      if (cnt == 100) begin rd_req = 1'b1; rd_addr = 10'd0; rd_ch = 1'b0; end
      if (cnt == 101) rd_req = 1'b0;
      if (cnt == 102) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_hit !== 1'b0 || rd_value !== 8'd0 || rd_ts !== 16'd0) begin
          errors++;
          $display("FAIL read_during_clear: valid=%b hit=%b value=%0d ts=%0d, want 1 0 0 0",
                   rd_valid, rd_hit, rd_value, rd_ts);
        end
      end
      if (cnt == 2000) begin
        ev_valid = 1'b1; ev_x = 5'd0; ev_y = 5'd0; ev_ch = 1'b0; ev_ts = 16'd77;
      end
      if (cnt == 2001) ev_valid = 1'b0;
      seen = init_done;
    end
    checks++;
    if (cnt !== 2048) begin
      errors++;
      $display("FAIL init_latency: init_done after %0d cycles, want 2048", cnt);
    end
    checks++;
    if (drop_count !== 16'd1) begin
      errors++;
      $display("FAIL drop_count: got %0d, want 1", drop_count);
    end
  endtask

  task automatic test_dropped_not_written;
    logic v1, v2, hit;
    logic [7:0] val;
    logic [15:0] ts;
    t_now = 16'd77; decay_mode = 2'd0;
    do_read(10'd0, 1'b0, v1, v2, val, hit, ts);
    checks++;
    if (v2 !== 1'b1 || hit !== 1'b0 || val !== 8'd0 || ts !== 16'd0) begin
      errors++;
      $display("FAIL dropped_event: valid=%b hit=%b value=%0d ts=%0d, want 1 0 0 0", v2, hit, val, ts);
    end
  endtask

  task automatic test_exponential;
    logic v1, v2, hit;
    logic [7:0] val;
    logic [15:0] ts;
    write_ev(5'd3, 5'd5, 1'b1, 16'd100);
    decay_mode = 2'd0;
    t_now = 16'd100;
    do_read(10'd163, 1'b1, v1, v2, val, hit, ts);
    checks++;
    if (v1 !== 1'b0 || v2 !== 1'b1) begin
      errors++;
      $display("FAIL exp_latency: valid at +1=%b +2=%b, want 0 1", v1, v2);
    end
    checks++;
    if (val !== 8'd255 || hit !== 1'b1 || ts !== 16'd100) begin
      errors++;
      $display("FAIL exp_dt0: value=%0d hit=%b ts=%0d, want 255 1 100", val, hit, ts);
    end
    t_now = 16'd228;
    do_read(10'd163, 1'b1, v1, v2, val, hit, ts);
    checks++;
    if (val !== 8'd63) begin
      errors++;
      $display("FAIL exp_dt128: value=%0d, want 63", val);
    end
    t_now = 16'd612;
    do_read(10'd163, 1'b1, v1, v2, val, hit, ts);
    checks++;
    if (val !== 8'd0 || hit !== 1'b1) begin
      errors++;
      $display("FAIL exp_dt512: value=%0d hit=%b, want 0 1", val, hit);
    end
    do_read(10'd163, 1'b0, v1, v2, val, hit, ts);
    checks++;
    if (hit !== 1'b0 || val !== 8'd0) begin
      errors++;
      $display("FAIL other_channel: hit=%b value=%0d, want 0 0", hit, val);
    end
  endtask

  task automatic test_modes;
    logic v1, v2, hit;
    logic [7:0] val;
    logic [15:0] ts;
    logic [1:0]  modes [5] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1};
    logic [15:0] tnows [5] = '{16'd228, 16'd228, 16'd228, 16'd400, 16'd400};
    logic [7:0]  exps  [5] = '{8'd223, 8'd255, 8'd63, 8'd0, 8'd180};
    for (int i = 0; i < 5; i++) begin
      decay_mode = modes[i];
      t_now = tnows[i];
      do_read(10'd163, 1'b1, v1, v2, val, hit, ts);
      checks++;
      if (val !== exps[i]) begin
        errors++;
        $display("FAIL mode%0d_dt%0d: value=%0d, want %0d", modes[i], tnows[i] - 16'd100, val, exps[i]);
      end
    end
  endtask

  task automatic test_wrap;
    logic v1, v2, hit;
    logic [7:0] val;
    logic [15:0] ts;
    decay_mode = 2'd0;
    write_ev(5'd0, 5'd1, 1'b0, 16'hFFF0);
    t_now = 16'h0010;
    do_read(10'd32, 1'b0, v1, v2, val, hit, ts);
    checks++;
    if (val !== 8'd255 || hit !== 1'b1 || ts !== 16'hFFF0) begin
      errors++;
      $display("FAIL wrap: value=%0d hit=%b ts=%h, want 255 1 fff0", val, hit, ts);
    end
    write_ev(5'd2, 5'd0, 1'b0, 16'd200);
    t_now = 16'd100;
    do_read(10'd2, 1'b0, v1, v2, val, hit, ts);
    checks++;
    if (val !== 8'd0 || hit !== 1'b1 || ts !== 16'd200) begin
      errors++;
      $display("FAIL future: value=%0d hit=%b ts=%0d, want 0 1 200", val, hit, ts);
    end
  endtask

  task automatic test_forward;
    decay_mode = 2'd0;
    t_now = 16'd500;
    @(negedge clk);
    ev_valid = 1'b1; ev_x = 5'd7; ev_y = 5'd7; ev_ch = 1'b0; ev_ts = 16'd500;
    rd_req = 1'b1; rd_addr = 10'd231; rd_ch = 1'b0;
    @(negedge clk);
    ev_valid = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_valid !== 1'b1 || rd_ts !== 16'd500 || rd_value !== 8'd255 || rd_hit !== 1'b1) begin
      errors++;
      $display("FAIL forward: valid=%b ts=%0d value=%0d hit=%b, want 1 500 255 1",
               rd_valid, rd_ts, rd_value, rd_hit);
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0]  addrs [4] = '{10'd163, 10'd32, 10'd2, 10'd231};
    logic        chs   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [15:0] tss   [4] = '{16'd100, 16'hFFF0, 16'd200, 16'd500};
    t_now = 16'd500;
    decay_mode = 2'd2;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      if (j >= 2 && j < 6) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_ts !== tss[j-2]) begin
          errors++;
          $display("FAIL b2b_%0d: valid=%b ts=%h, want 1 %h", j - 2, rd_valid, rd_ts, tss[j-2]);
        end
      end else if (j == 6) begin
        checks++;
        if (rd_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_tail: valid=%b, want 0", rd_valid);
        end
      end
      if (j < 4) begin
        rd_req = 1'b1; rd_addr = addrs[j]; rd_ch = chs[j];
      end else begin
        rd_req = 1'b0;
      end
    end
    checks++;
    if (rd_value !== 8'd255) begin
      errors++;
      $display("FAIL b2b_window: value=%0d, want 255", rd_value);
    end
  endtask

  task automatic test_mid_reset;
    logic v1, v2, hit;
    logic [7:0] val;
    logic [15:0] ts;
    int stray;
    logic [9:0] addrs [4] = '{10'd163, 10'd32, 10'd2, 10'd231};
    logic       chs   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    @(negedge clk);
    rd_req = 1'b1; rd_addr = 10'd163; rd_ch = 1'b1;
    @(negedge clk);
    rd_addr = 10'd32; rd_ch = 1'b0;
    @(negedge clk);
    rd_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || init_done !== 1'b0 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b init=%b drop=%0d, want 0 0 0", rd_valid, init_done, drop_count);
    end
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (rd_valid) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL inflight_discard: %0d stray rd_valid cycles, want 0", stray);
    end
    wait_init("mid_reset_init");
    t_now = 16'd500;
    decay_mode = 2'd0;
    for (int i = 0; i < 4; i++) begin
      do_read(addrs[i], chs[i], v1, v2, val, hit, ts);
      checks++;
      if (v2 !== 1'b1 || hit !== 1'b0 || val !== 8'd0 || ts !== 16'd0) begin
        errors++;
        $display("FAIL cleared_%0d: valid=%b hit=%b value=%0d ts=%0d, want 1 0 0 0", i, v2, hit, val, ts);
      end
    end
  endtask

  initial begin
    rst = 1'b1; t_now = '0; decay_mode = '0;
    ev_valid = 1'b0; ev_x = '0; ev_y = '0; ev_ch = '0; ev_ts = '0;
    rd_req = 1'b0; rd_addr = '0; rd_ch = '0;
    test_reset();
    test_init();
    test_dropped_not_written();
    test_exponential();
    test_modes();
    test_wrap();
    test_forward();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/polar_time_surface.md
Name: polar_time_surface

Overview:
Multi-channel (per-polarity) time-surface store for the gradient-map path. It holds the last-event timestamp and a valid flag per cell per channel. Decay is computed lazily on read, and the decay law is selectable at run time. It sits between the event decoder (write side) and the feature-extraction scanner (read side), and adds self-clearing initialisation, write-to-read forwarding and wrap-safe age arithmetic.

Parameters:
GRID_SIZE, 32, grid dimension (GRID_SIZE x GRID_SIZE cells per channel)
NUM_CH, 2, channel count (polarity planes); CH_BITS = max(1, clog2(NUM_CH))
TS_BITS, 16, timestamp width
VALUE_BITS, 8, decayed output width
MAX_VALUE, 255, surface value at age 0
DECAY_SHIFT, 6, exponential half-life = 2^DECAY_SHIFT ticks
LIN_SHIFT, 2, linear mode slope: one value step per 2^LIN_SHIFT ticks
WINDOW, 256, window mode: age < WINDOW gives MAX_VALUE, otherwise 0

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
t_now  in  TS_BITS  global timestamp, sampled in read stage 2
decay_mode  in  2  0 = exponential, 1 = linear, 2 = window, 3 = raw (reserved, behaves as 0)
ev_valid  in  1  event write strobe
ev_x, ev_y  in  clog2(GRID_SIZE) each  event cell coordinates
ev_ch  in  CH_BITS  event channel/polarity
ev_ts  in  TS_BITS  event timestamp
rd_req  in  1  read request, one accepted per cycle, no backpressure
rd_addr  in  clog2(GRID_SIZE^2)  linear cell address, y*GRID_SIZE + x
rd_ch  in  CH_BITS  channel to read
rd_valid  out  1  result strobe
rd_value  out  VALUE_BITS  decayed value
rd_hit  out  1  cell has been written since init
rd_ts  out  TS_BITS  raw stored timestamp
init_done  out  1  clear sweep complete
drop_count  out  16  events dropped during init, saturating

Behaviour:
- Storage: one array of NUM_CH*GRID_SIZE^2 entries, each {valid, ts}. Index = ch*GRID_SIZE^2 + cell. One write port, one synchronous read port; must infer block RAM.
- Reset values: rd_valid=0, rd_value=0, rd_hit=0, rd_ts=0, init_done=0, drop_count=0. The read pipeline is flushed.
- FSM CLEAR:
  - Entered on rst. While rst is high, the sweep address is held at 0.
  - After rst drops, writes valid=0 to one entry per cycle, addresses 0..DEPTH-1.
  - Moves to READY on the cycle after the last write. init_done=1 from then until the next rst.
  - Duration is DEPTH cycles after rst deassert (2048 at defaults).
- FSM READY: ev_valid writes {1, ev_ts} at the event index in the same cycle.
- Events during CLEAR: discarded; drop_count increments by 1 and saturates at 0xFFFF.
- rst mid-operation: the sweep restarts from 0, in-flight reads are discarded (no rd_valid), and drop_count is cleared.
- Read pipeline: rd_req in cycle N gives rd_valid in cycle N+2. Fully pipelined, one result per cycle.
  - Stage 1: RAM read.
  - Stage 2: decay computation, registered.
- Read during CLEAR: accepted and returns rd_valid with rd_hit=0, rd_value=0, rd_ts=0.
- Forwarding: if ev_valid (in READY) targets the same index as rd_req in the same cycle, stage 1 returns {1, ev_ts} (write-first).
- Age: dt = (t_now - ts) mod 2^TS_BITS.
  - If dt[TS_BITS-1]=1, the entry is treated as expired or future and rd_value=0.
  - This gives correct results across t_now wrap for true ages < 2^(TS_BITS-1).
- Decay laws (only when hit=1 and not expired):
  - exponential: k = dt >> DECAY_SHIFT; value = MAX_VALUE >> k; value = 0 if k >= VALUE_BITS.
  - linear: s = dt >> LIN_SHIFT; value = MAX_VALUE - min(MAX_VALUE, s).
  - window: value = MAX_VALUE if dt < WINDOW, else 0.
- rd_hit=0 forces rd_value=0; rd_ts still reflects stored data.
- All arithmetic is unsigned. Intermediate shifts use TS_BITS width, and the result is truncated to VALUE_BITS only after saturation.
- decay_mode is sampled in stage 2 and may change every cycle.

Test Plan:
- Init: pulse rst, then hold idle → init_done rises exactly 2048 cycles after rst falls. Then read addr 0, ch 0 → rd_hit=0, rd_value=0. Event during CLEAR → drop_count=1 and no write occurs.
- Exponential: write (x=3, y=5, ch=1, ts=100), read addr 163 ch 1.
  - t_now=100 → 255, hit=1, rd_ts=100, rd_valid exactly 2 cycles after rd_req.
  - t_now=228 → 63.
  - t_now=612 → 0.
  - Read addr 163 ch 0 → hit=0.
- Modes at dt=128: linear → 223; window → 255. At dt=300: window → 0; linear → 180.
- Wrap and future:
  - ts=0xFFF0, t_now=0x0010 → dt=32, exponential value 255.
  - ts=200, t_now=100 → value 0, hit=1.
- Forwarding and throughput:
  - Same-cycle write ts=500 plus read of the same index, t_now=500 → rd_ts=500, value=255.
  - Back-to-back reads on 4 addresses → 4 consecutive rd_valid cycles, in order.
- Reset mid-stream: assert rst with reads in flight → no rd_valid afterwards, init_done=0, and after 2048 cycles all cells read hit=0.
